// File: rtl/blit_loop_cnt_if.sv
// Bus bundle between the blitter sequencer (master) and the two-level loop counter (slave).
interface blit_loop_cnt_if #(
    parameter int unsigned INNER_W = 16,
    parameter int unsigned OUTER_W = 16,
    parameter int unsigned DIN_W   = 32
);
    logic               countld;
    logic [DIN_W-1:0]   gpu_din;
    logic               step;
    logic               abort;
    logic               busy;
    logic               inner0;
    logic               outer0;
    logic               inner_last;
    logic               outer_last;
    logic               inner_wrap;
    logic               done;
    logic [INNER_W-1:0] icnt;
    logic [OUTER_W-1:0] ocnt;

    modport master (
        output countld, gpu_din, step, abort,
        input  busy, inner0, outer0, inner_last, outer_last, inner_wrap, done, icnt, ocnt
    );

    modport slave (
        input  countld, gpu_din, step, abort,
        output busy, inner0, outer0, inner_last, outer_last, inner_wrap, done, icnt, ocnt
    );
endinterface

// File: rtl/blit_loop_cnt.sv
// Two-level (inner/outer) loop counter for the blitter sequencer.
// The inner count reloads from a shadow copy at each inner-loop end while the
// outer count steps down; a zero in either field is treated as an empty loop.
module blit_loop_cnt #(
    parameter int unsigned INNER_W   = 16,
    parameter int unsigned OUTER_W   = 16,
    parameter int unsigned DIN_W     = 32,
    parameter int unsigned OUTER_LSB = 16
) (
    input  logic            clk,
    input  logic            reset,
    blit_loop_cnt_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [INNER_W-1:0] icnt_q, icnt_next;
    logic [OUTER_W-1:0] ocnt_q, ocnt_next;
    logic [INNER_W-1:0] shadow_q, shadow_next;
    logic               wrap_q, wrap_next;
    logic               done_q;

    logic [INNER_W-1:0] inner_field;
    logic [OUTER_W-1:0] outer_field;
    logic               unused_din;

    // Split the load word into its two count fields.
    assign inner_field = bus.gpu_din[INNER_W-1:0];
    assign outer_field = bus.gpu_din[OUTER_LSB +: OUTER_W];
    assign unused_din  = ^bus.gpu_din;

    // State, counters and the two pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            icnt_q   <= '0;
            ocnt_q   <= '0;
            shadow_q <= '0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            icnt_q   <= icnt_next;
            ocnt_q   <= ocnt_next;
            shadow_q <= shadow_next;
            wrap_q   <= wrap_next;
            done_q   <= (state_next == DONE);
        end
    end

    // Next-state and counter update; load beats abort beats step.
    always_comb begin
        state_next  = state;
        icnt_next   = icnt_q;
        ocnt_next   = ocnt_q;
        shadow_next = shadow_q;
        wrap_next   = 1'b0;

        if (bus.countld) begin
            shadow_next = inner_field;
            if ((inner_field != '0) && (outer_field != '0)) begin
                icnt_next  = inner_field;
                ocnt_next  = outer_field;
                state_next = RUN;
            end else begin
                icnt_next  = '0;
                ocnt_next  = '0;
                state_next = DONE;
            end
        end else if (bus.abort) begin
            if (state != IDLE) begin
                icnt_next  = '0;
                ocnt_next  = '0;
                state_next = IDLE;
            end
        end else begin
            case (state)
                RUN: begin
                    if (bus.step) begin
                        if (icnt_q > INNER_W'(1)) begin
                            icnt_next = icnt_q - INNER_W'(1);
                        end else if (icnt_q == INNER_W'(1)) begin
                            if (ocnt_q > OUTER_W'(1)) begin
                                icnt_next = shadow_q;
                                ocnt_next = ocnt_q - OUTER_W'(1);
                                wrap_next = 1'b1;
                            end else begin
                                icnt_next  = '0;
                                ocnt_next  = '0;
                                state_next = DONE;
                            end
                        end
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    // Status decoded from the registered state and counters.
    assign bus.busy       = (state == RUN);
    assign bus.inner0     = (icnt_q == '0);
    assign bus.outer0     = (ocnt_q == '0);
    assign bus.inner_last = (state == RUN) && (icnt_q == INNER_W'(1));
    assign bus.outer_last = (state == RUN) && (ocnt_q == OUTER_W'(1));
    assign bus.inner_wrap = wrap_q;
    assign bus.done       = done_q;
    assign bus.icnt       = icnt_q;
    assign bus.ocnt       = ocnt_q;

endmodule

// File: tb/tb_blit_loop_cnt.sv
// Bench for blit_loop_cnt: default-width instance checked cycle by cycle against
// a step-count model, plus a narrow-field instance for the parameter sweep.
module tb_blit_loop_cnt;

    logic clk;
    logic reset;

    blit_loop_cnt_if #(.INNER_W(16), .OUTER_W(16), .DIN_W(32)) bus ();
    blit_loop_cnt_if #(.INNER_W(4),  .OUTER_W(8),  .DIN_W(32)) bus2 ();

    blit_loop_cnt #(.INNER_W(16), .OUTER_W(16), .DIN_W(32), .OUTER_LSB(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    blit_loop_cnt #(.INNER_W(4), .OUTER_W(8), .DIN_W(32), .OUTER_LSB(8)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a loop of I x O iterations is fully described by the step count k.
    int     m_state = 0;   // 0 idle, 1 run, 2 done
    longint m_i = 0;
    longint m_o = 0;
    longint m_k = 0;
    logic   m_wrap = 1'b0;

    function automatic void model_step(logic rst, logic ld, logic [31:0] din, logic stp, logic abt);
        m_wrap = 1'b0;
        if (rst) begin
            m_state = 0; m_i = 0; m_o = 0; m_k = 0;
        end else if (ld) begin
            m_i = longint'(din[15:0]);
            m_o = longint'(din[31:16]);
            m_k = 0;
            m_state = (m_i != 0 && m_o != 0) ? 1 : 2;
        end else if (abt) begin
            m_state = 0;
        end else if (m_state == 1 && stp) begin
            m_k = m_k + 1;
            if (m_k == m_i * m_o) m_state = 2;
            else if (m_k % m_i == 0) m_wrap = 1'b1;
        end else if (m_state == 2) begin
            m_state = 0;
        end
    endfunction

    function automatic logic [38:0] exp_vec();
        logic        run;
        logic [15:0] ei, eo;
        run = (m_state == 1);
        ei = run ? 16'(m_i - (m_k % m_i)) : 16'd0;
        eo = run ? 16'(m_o - (m_k / m_i)) : 16'd0;
        return {run, ei == 16'd0, eo == 16'd0, run && ei == 16'd1, run && eo == 16'd1,
                m_wrap, m_state == 2, ei, eo};
    endfunction

    function automatic logic [38:0] obs_vec();
        return {bus.busy, bus.inner0, bus.outer0, bus.inner_last, bus.outer_last,
                bus.inner_wrap, bus.done, bus.icnt, bus.ocnt};
    endfunction

    function automatic logic [18:0] obs2_vec();
        return {bus2.busy, bus2.inner0, bus2.outer0, bus2.inner_last, bus2.outer_last,
                bus2.inner_wrap, bus2.done, bus2.icnt, bus2.ocnt};
    endfunction

    task automatic drive(logic ld, logic [31:0] din, logic stp, logic abt);
        bus.countld = ld;
        bus.gpu_din = din;
        bus.step    = stp;
        bus.abort   = abt;
    endtask

    // One clock: the model sees the same inputs the DUT samples on this edge.
    task automatic tick();
        @(posedge clk);
        model_step(reset, bus.countld, bus.gpu_din, bus.step, bus.abort);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        n_checks++;
        if (obs_vec() !== {7'b0110000, 32'h0}) begin
            n_fail++;
            $display("FAIL reset: got %h expected %h", obs_vec(), {7'b0110000, 32'h0});
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_basic();
        int wraps = 0;
        int dones = 0;
        drive(1'b1, 32'h0003_0004, 1'b0, 1'b0);
        tick();
        n_checks++;
        if ({bus.busy, bus.icnt, bus.ocnt} !== {1'b1, 16'd4, 16'd3}) begin
            n_fail++;
            $display("FAIL basic_load: got %h expected %h", {bus.busy, bus.icnt, bus.ocnt}, {1'b1, 16'd4, 16'd3});
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int c = 0; c < 15; c++) begin
            if (c == 12) bus.step = 1'b0;
            tick();
            wraps += int'(bus.inner_wrap);
            dones += int'(bus.done);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL basic cyc%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (wraps != 2 || dones != 1) begin
            n_fail++;
            $display("FAIL basic_pulses: got wraps=%0d dones=%0d expected wraps=2 dones=1", wraps, dones);
        end
    endtask

    task automatic test_zero_count();
        logic [31:0] loads [2];
        loads[0] = 32'h0000_0005;
        loads[1] = 32'h0002_0000;
        for (int n = 0; n < 2; n++) begin
            drive(1'b1, loads[n], 1'b0, 1'b0);
            tick();
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            n_checks++;
            if (obs_vec() !== {7'b0110001, 32'h0}) begin
                n_fail++;
                $display("FAIL zero_done%0d: got %h expected %h", n, obs_vec(), {7'b0110001, 32'h0});
            end
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL zero_idle%0d: got %h expected %h", n, obs_vec(), exp_vec());
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_gapped_reload();
        drive(1'b1, 32'h0002_0002, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        bus.step = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec() || bus.icnt !== 16'd1) begin
                n_fail++;
                $display("FAIL gap_hold%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        drive(1'b1, 32'h0001_0001, 1'b1, 1'b0);
        tick();
        n_checks++;
        if ({bus.busy, bus.icnt, bus.ocnt} !== {1'b1, 16'd1, 16'd1} || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL gap_reload: got %h expected %h", obs_vec(), exp_vec());
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        bus.step = 1'b0;
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL gap_done: got %h expected %h", obs_vec(), exp_vec());
        end
        tick();
    endtask

    task automatic test_abort();
        drive(1'b1, 32'h0004_0004, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) tick();
        n_checks++;
        if ({bus.icnt, bus.ocnt} !== {16'd3, 16'd3}) begin
            n_fail++;
            $display("FAIL abort_pre: got %h expected %h", {bus.icnt, bus.ocnt}, {16'd3, 16'd3});
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (obs_vec() !== {7'b0110000, 32'h0}) begin
                n_fail++;
                $display("FAIL abort_idle%0d: got %h expected %h", c, obs_vec(), {7'b0110000, 32'h0});
            end
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h0001_0002, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0002_0003, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int c = 0; c < 9; c++) begin
            if (bus.done === 1'b1) drive(1'b1, 32'h0001_0002, 1'b1, 1'b0);
            else drive(1'b0, 32'h0, 1'b1, 1'b0);
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b cyc%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_random();
        logic [31:0] din;
        for (int c = 0; c < 3000; c++) begin
            din = {16'($urandom_range(0, 4)), 16'($urandom_range(0, 5))};
            if ($urandom_range(0, 9) == 0) din = $urandom;
            reset = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 19) == 0, din, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_param_sweep();
        logic [18:0] exp2;
        bus2.countld = 1'b1;
        bus2.gpu_din = 32'hFFFF_FFFF;
        bus2.step    = 1'b0;
        bus2.abort   = 1'b0;
        tick();
        bus2.countld = 1'b0;
        bus2.step    = 1'b1;
        n_checks++;
        if (obs2_vec() !== {7'b1000000, 4'hF, 8'hFF}) begin
            n_fail++;
            $display("FAIL sweep_load: got %h expected %h", obs2_vec(), {7'b1000000, 4'hF, 8'hFF});
        end
        for (int k = 1; k <= 3825; k++) begin
            tick();
            if (k < 3825)
                exp2 = {1'b1, 1'b0, 1'b0, (15 - k % 15) == 1, (255 - k / 15) == 1,
                        k % 15 == 0, 1'b0, 4'(15 - k % 15), 8'(255 - k / 15)};
            else
                exp2 = {7'b0110001, 4'h0, 8'h00};
            n_checks++;
            if (obs2_vec() !== exp2) begin
                n_fail++;
                $display("FAIL sweep step%0d: got %h expected %h", k, obs2_vec(), exp2);
            end
        end
        bus2.step = 1'b0;
        tick();
        n_checks++;
        if (obs2_vec() !== {7'b0110000, 12'h0}) begin
            n_fail++;
            $display("FAIL sweep_idle: got %h expected %h", obs2_vec(), {7'b0110000, 12'h0});
        end
        bus2.countld = 1'b1;
        tick();
        bus2.countld = 1'b0;
        bus2.step    = 1'b1;
        for (int k = 0; k < 100; k++) tick();
        n_checks++;
        if ({bus2.icnt, bus2.ocnt} !== {4'(15 - 100 % 15), 8'(255 - 100 / 15)}) begin
            n_fail++;
            $display("FAIL sweep_mid: got %h expected %h", {bus2.icnt, bus2.ocnt}, {4'(15 - 100 % 15), 8'(255 - 100 / 15)});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (obs2_vec() !== {7'b0110000, 12'h0}) begin
                n_fail++;
                $display("FAIL sweep_reset%0d: got %h expected %h", c, obs2_vec(), {7'b0110000, 12'h0});
            end
            tick();
        end
        bus2.step = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        bus2.countld = 1'b0;
        bus2.gpu_din = 32'h0;
        bus2.step    = 1'b0;
        bus2.abort   = 1'b0;
        test_reset();
        test_basic();
        test_zero_count();
        test_gapped_reload();
        test_abort();
        test_back_to_back();
        test_random();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/blit_loop_cnt.md
Name: blit_loop_cnt

Overview:
Parametrised two-level loop counter for the blitter, successor to the single outer-loop counter. Loads inner and outer iteration counts in one bus write, runs the inner count down on each step, auto-reloads the inner count from a shadow register at each inner-loop end and decrements the outer count. Signals loop boundaries and a completion pulse to the blitter sequencer. Adds abort, count readback and zero-count handling.

Parameters:
INNER_W, 16, inner counter width in bits (1..16)
OUTER_W, 16, outer counter width in bits (1..16)
DIN_W, 32, load bus width
OUTER_LSB, 16, bit position of the outer field in gpu_din; must satisfy OUTER_LSB+OUTER_W <= DIN_W and OUTER_LSB >= INNER_W

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
countld  in  1  load strobe: captures both counts from gpu_din
gpu_din  in  DIN_W  load data; inner = gpu_din[INNER_W-1:0], outer = gpu_din[OUTER_LSB+OUTER_W-1:OUTER_LSB]
step  in  1  advance one inner iteration (ignored unless busy)
abort  in  1  cancel the running loop
busy  out  1  high while state RUN
inner0  out  1  inner counter == 0
outer0  out  1  outer counter == 0
inner_last  out  1  RUN and inner counter == 1 (current step ends inner loop)
outer_last  out  1  RUN and outer counter == 1
inner_wrap  out  1  one-cycle registered pulse: inner loop ended, outer not yet exhausted
done  out  1  one-cycle registered pulse: whole loop complete
icnt  out  INNER_W  inner counter readback
ocnt  out  OUTER_W  outer counter readback

Behaviour:
- State machine: IDLE, RUN, DONE (encoding free).
- Reset: state IDLE; icnt, ocnt, shadow = 0; busy 0, inner_wrap 0, done 0; inner0 = outer0 = 1; inner_last = outer_last = 0.
- inner0, outer0, inner_last, outer_last, busy: combinational from registered state/counters. inner_wrap, done: registered.
- Load (countld, any state): shadow <= inner field, icnt <= inner field, ocnt <= outer field. If both fields nonzero -> RUN; else -> DONE with icnt, ocnt forced to 0 (zero count = empty loop, never 2^W). Load during RUN restarts; step in the same cycle ignored.
- Priority per cycle: reset > countld > abort > step.
- abort (no countld): from any state -> IDLE, icnt, ocnt <= 0, no done pulse. abort in IDLE is a no-op.
- RUN, step=1:
  - icnt > 1: icnt <= icnt-1.
  - icnt == 1, ocnt > 1: icnt <= shadow, ocnt <= ocnt-1, inner_wrap = 1 next cycle.
  - icnt == 1, ocnt == 1: icnt <= 0, ocnt <= 0, -> DONE.
- RUN, step=0: hold.
- DONE: done = 1 for exactly the cycle the state is DONE; next cycle -> IDLE unless countld.
- Steps in IDLE/DONE ignored; counters hold.
- Latency: the final step is followed by done high on the next cycle, busy low in the same cycle. Back-to-back step every cycle is supported; total steps to completion = inner*outer.
- Arithmetic: unsigned, no wrap past zero; counters never decrement from 0.
- Reset mid-operation: immediate return to reset values on the next edge; pending inner_wrap/done suppressed.

Test Plan:
- Reset then idle: reset 2 cycles -> busy 0, inner0 1, outer0 1, icnt 0, ocnt 0, done 0.
- Load gpu_din=0x0003_0004 (outer 3, inner 4), step every cycle -> busy after load, inner_wrap pulses after steps 4 and 8, icnt reloads to 4, ocnt 3->2->1, inner_last on steps 4/8/12, done one cycle after step 12, then IDLE.
- Zero count: load 0x0000_0005 and, separately, 0x0002_0000 -> busy never high, done pulses next cycle, icnt and ocnt read 0.
- Gapped steps + mid-run reload: load 0x0002_0002, 1 step, 3 idle cycles (counters hold), then countld 0x0001_0001 with step high -> restart, icnt 1, ocnt 1; one step -> done.
- Abort: load 0x0004_0004, 5 steps (icnt 3, ocnt 3), abort with step high -> IDLE, icnt 0, ocnt 0, no done; subsequent steps ignored.
- Parameter sweep INNER_W=4, OUTER_W=8, OUTER_LSB=8: load inner 0xF, outer 0xFF (other bits set to 1) -> done after exactly 3825 steps; reset asserted at step 100 -> reset values, no done.
